// File: rtl/bcd_serial_addsub_pkg.sv
// Shared types and digit helpers for the serial packed-BCD adder/subtractor.
package bcd_serial_addsub_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // A nibble above 9 is not a decimal digit.
    function automatic logic is_bad_digit(input bcd_digit_t d);
        return d > BCD_MAX;
    endfunction

    // Nine's complement of one digit, wrapping to 4 bits for non-decimal nibbles.
    function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
        return BCD_MAX - d;
    endfunction

endpackage

// File: rtl/bcd_serial_addsub_if.sv
// Operand/result handshake bundle for the serial BCD adder/subtractor.
interface bcd_serial_addsub_if #(
    parameter int N_DIGITS = 4
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [4*N_DIGITS-1:0] a;
    logic [4*N_DIGITS-1:0] b;
    logic                  cin;
    logic                  sub;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*N_DIGITS-1:0] sum;
    logic                  cout;
    logic                  neg;
    logic                  err;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, neg, err
    );

    // The arithmetic block itself.
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, neg, err
    );
endinterface

// File: rtl/bcd_serial_addsub_digit_add.sv
// Single-digit decimal add with carry; shared by every digit position in turn.
module bcd_digit_add
    import bcd_serial_addsub_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       c_in,
    output bcd_digit_t digit,
    output logic       c_out
);

    logic [4:0] t;

    // Binary sum of the two nibbles, corrected by -10 when it exceeds 9.
    always_comb begin
        t = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
        if (t > 5'd9) begin
            digit = 4'(t - 5'd10);
            c_out = 1'b1;
        end else begin
            digit = t[3:0];
            c_out = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Multi-digit packed-BCD adder/subtractor, one digit per clock, LSD first.
// Subtraction is done as A + nines(B) + ~borrow; the final carry means "not negative".
module bcd_serial_addsub
    import bcd_serial_addsub_pkg::*;
#(
    parameter int N_DIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bcd_serial_addsub_if.slave     bus
);

    localparam int W     = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(N_DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_DIGITS);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [W-1:0]     sum_r;
    logic             cout_r;
    logic             neg_r;
    logic             err_r;

    logic [W-1:0]     a_sh;
    logic [W-1:0]     b_sh;
    logic [W-1:0]     res_sh;
    logic             c;
    logic             sub_r;
    logic             err_pend;

    logic [W-1:0]     b_nines;
    logic             in_bad;
    logic             accept;
    logic             stepping;
    bcd_digit_t       dig;
    logic             c_next;

    assign accept   = (state == IDLE) && bus.in_valid;
    assign stepping = (state == RUN) && (cnt != LAST);

    // Per-digit nine's complement of B and raw-operand digit validity.
    always_comb begin
        b_nines = '0;
        in_bad  = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            b_nines[4*k +: 4] = nines_comp(bus.b[4*k +: 4]);
            in_bad = in_bad | is_bad_digit(bus.a[4*k +: 4]) | is_bad_digit(bus.b[4*k +: 4]);
        end
    end

    bcd_digit_add u_digit (
        .a     (a_sh[3:0]),
        .b     (b_sh[3:0]),
        .c_in  (c),
        .digit (dig),
        .c_out (c_next)
    );

    // Operand capture and digit-serial shifting; aborted work is simply abandoned.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh     <= bus.a;
            b_sh     <= bus.sub ? b_nines : bus.b;
            c        <= bus.sub ? ~bus.cin : bus.cin;
            sub_r    <= bus.sub;
            err_pend <= in_bad;
        end else if (stepping) begin
            a_sh   <= a_sh >> 4;
            b_sh   <= b_sh >> 4;
            res_sh <= (res_sh >> 4) | (W'(dig) << (W - 4));
            c      <= c_next;
        end
    end

    // Control FSM: N_DIGITS digit steps, one cycle to publish, then hold until taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            neg_r       <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        cnt        <= '0;
                        in_ready_r <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == LAST) begin
                        sum_r       <= res_sh;
                        cout_r      <= c;
                        neg_r       <= sub_r & ~c;
                        err_r       <= err_pend;
                        out_valid_r <= 1'b1;
                        cnt         <= '0;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.neg       = neg_r;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub: decimal-arithmetic reference model, random and directed operations.
module tb_bcd_serial_addsub;

    typedef struct packed {
        logic        err;
        logic        neg;
        logic        cout;
        logic [63:0] sum;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_serial_addsub_if #(.N_DIGITS(4)) bus4 ();
    bcd_serial_addsub_if #(.N_DIGITS(1)) bus1 ();

    bcd_serial_addsub #(.N_DIGITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    bcd_serial_addsub #(.N_DIGITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int   total = 0;
    int   bad   = 0;
    res_t exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic res_t mk(input logic err, neg, cout, input logic [63:0] sum);
        res_t r;
        r.err = err; r.neg = neg; r.cout = cout; r.sum = sum;
        return r;
    endfunction

    // Reference: plain decimal arithmetic when all digits are legal,
    // digit-by-digit rule when some nibble is out of range.
    function automatic res_t model(input int n, input logic [63:0] a, b, input logic cin, sub);
        res_t   r;
        logic   badd;
        longint av, bv, m, s;
        logic [3:0] da, db, bd, d;
        logic   c;
        int     t;
        r = '0; badd = 1'b0; av = 0; bv = 0; m = 1;
        for (int k = n - 1; k >= 0; k--) begin
            da = a[4*k +: 4];
            db = b[4*k +: 4];
            if (da > 4'd9 || db > 4'd9) badd = 1'b1;
            av = av * 10 + longint'(da);
            bv = bv * 10 + longint'(db);
            m  = m * 10;
        end
        r.err = badd;
        if (!badd) begin
            if (!sub) begin
                s = av + bv + longint'(cin);
                r.cout = (s >= m);
                if (r.cout) s = s - m;
            end else begin
                s = av - bv - longint'(cin);
                r.cout = (s >= 0);
                if (!r.cout) s = s + m;
            end
            for (int k = 0; k < n; k++) begin
                r.sum[4*k +: 4] = 4'(s % 10);
                s = s / 10;
            end
        end else begin
            c = sub ? ~cin : cin;
            for (int k = 0; k < n; k++) begin
                da = a[4*k +: 4];
                db = b[4*k +: 4];
                bd = sub ? 4'(4'd9 - db) : db;
                t  = int'(da) + int'(bd) + int'(c);
                if (t > 9) begin d = 4'(t - 10); c = 1'b1; end
                else       begin d = 4'(t);      c = 1'b0; end
                r.sum[4*k +: 4] = d;
            end
            r.cout = c;
        end
        r.neg = sub & ~r.cout;
        return r;
    endfunction

    // Result scoreboard and hold-stability checks for the 4-digit instance.
    logic        prev_hold = 1'b0;
    logic [15:0] prev_sum;
    logic        prev_cout, prev_neg, prev_err;
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_valid_exclusive", 128'(bus4.in_ready & bus4.out_valid), 128'(0));
            if (bus4.out_valid) begin
                if (prev_hold) begin
                    check("hold_sum", 128'(bus4.sum), 128'(prev_sum));
                    check("hold_flags", 128'({bus4.cout, bus4.neg, bus4.err}),
                          128'({prev_cout, prev_neg, prev_err}));
                end
                if (bus4.out_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_result");
                    end else begin
                        res_t e;
                        e = exp_q.pop_front();
                        check("result_sum", 128'(bus4.sum), 128'(e.sum[15:0]));
                        check("result_cout", 128'(bus4.cout), 128'(e.cout));
                        check("result_neg", 128'(bus4.neg), 128'(e.neg));
                        check("result_err", 128'(bus4.err), 128'(e.err));
                    end
                end
            end
            prev_hold = bus4.out_valid & ~bus4.out_ready;
            prev_sum  = bus4.sum;
            prev_cout = bus4.cout;
            prev_neg  = bus4.neg;
            prev_err  = bus4.err;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic send4(input logic [15:0] a, b, input logic cin, sub, input int hold, input bit poke);
        int n;
        n = 0;
        while (!bus4.in_ready && n < 50) begin @(negedge clk); n++; end
        if (!bus4.in_ready) begin fail_now("in_ready_wait"); return; end
        @(negedge clk);
        bus4.a = a; bus4.b = b; bus4.cin = cin; bus4.sub = sub; bus4.in_valid = 1'b1;
        exp_q.push_back(model(4, 64'(a), 64'(b), cin, sub));
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        bus4.a = 16'($urandom); bus4.b = 16'($urandom);
        bus4.cin = 1'($urandom); bus4.sub = 1'($urandom);
        n = 0;
        while (!bus4.out_valid && n < 40) begin
            bus4.in_valid = poke & n[0];
            @(posedge clk); #1;
            n++;
        end
        bus4.in_valid = 1'b0;
        check("latency", 128'(n), 128'(5));
        repeat (hold) begin
            @(posedge clk); #1;
            check("busy_while_held", 128'(bus4.in_ready), 128'(0));
        end
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        bus4.out_ready = 1'b0;
        check("out_valid_drop", 128'(bus4.out_valid), 128'(0));
        check("in_ready_back", 128'(bus4.in_ready), 128'(1));
    endtask

    task automatic send1(input logic [3:0] a, b, input logic cin, sub);
        int   n;
        res_t e;
        e = model(1, 64'(a), 64'(b), cin, sub);
        @(negedge clk);
        bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.sub = sub; bus1.in_valid = 1'b1;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        n = 0;
        while (!bus1.out_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("n1_latency", 128'(n), 128'(2));
        check("n1_sum", 128'(bus1.sum), 128'(e.sum[3:0]));
        check("n1_flags", 128'({bus1.cout, bus1.neg, bus1.err}), 128'({e.cout, e.neg, e.err}));
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
    endtask

    function automatic logic [15:0] rand_operand();
        logic [15:0] v;
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 19) == 0) v[4*k +: 4] = 4'($urandom_range(10, 15));
            else                            v[4*k +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus4.in_valid = 0; bus4.a = 0; bus4.b = 0; bus4.cin = 0; bus4.sub = 0; bus4.out_ready = 0;
        bus1.in_valid = 0; bus1.a = 0; bus1.b = 0; bus1.cin = 0; bus1.sub = 0; bus1.out_ready = 0;

        // Model pinned to hand-worked cases.
        check("pin_add", model(4, 64'h0019, 64'h0009, 1'b0, 1'b0), mk(0, 0, 0, 64'h0028));
        check("pin_carry", model(4, 64'h9999, 64'h0001, 1'b0, 1'b0), mk(0, 0, 1, 64'h0000));
        check("pin_n1", model(1, 64'h9, 64'h9, 1'b1, 1'b0), mk(0, 0, 1, 64'h9));
        check("pin_sub_pos", model(4, 64'h0050, 64'h0025, 1'b0, 1'b1), mk(0, 0, 1, 64'h0025));
        check("pin_sub_neg", model(4, 64'h0025, 64'h0050, 1'b0, 1'b1), mk(0, 1, 0, 64'h9975));
        check("pin_bad", model(4, 64'h00A1, 64'h0000, 1'b0, 1'b0), mk(1, 0, 0, 64'h0101));

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 128'(bus4.in_ready), 128'(1));
        check("reset_out_valid", 128'(bus4.out_valid), 128'(0));
        check("reset_outputs", 128'({bus4.sum, bus4.cout, bus4.neg, bus4.err}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        send4(16'h0019, 16'h0009, 1'b0, 1'b0, 0, 0);
        send4(16'h9999, 16'h0001, 1'b0, 1'b0, 0, 0);
        send4(16'h0050, 16'h0025, 1'b0, 1'b1, 0, 0);
        send4(16'h0025, 16'h0050, 1'b0, 1'b1, 3, 1);
        send4(16'h00A1, 16'h0000, 1'b0, 1'b0, 0, 0);
        send4(16'h1234, 16'h4321, 1'b1, 1'b0, 0, 0);
        send4(16'h0F07, 16'h00B3, 1'b1, 1'b1, 1, 1);

        // Abort while digit 2 is being processed.
        @(negedge clk);
        bus4.a = 16'h5555; bus4.b = 16'h4444; bus4.cin = 1'b0; bus4.sub = 1'b0; bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_out_valid", 128'(bus4.out_valid), 128'(0));
        check("abort_in_ready", 128'(bus4.in_ready), 128'(1));
        check("abort_outputs", 128'({bus4.sum, bus4.cout, bus4.neg, bus4.err}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        send4(16'h0808, 16'h0909, 1'b0, 1'b0, 2, 0);

        for (int i = 0; i < 30; i++) begin
            send4(rand_operand(), rand_operand(), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        send1(4'h9, 4'h9, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            send1(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 1'($urandom), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        if (exp_q.size() != 0) fail_now("results_missing");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
